// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   // Upper bound on {tag, payload}; the packing helper works at this width
   // and callers truncate to their real width.
   localparam int unsigned TAG_MAXW = 128;

   function automatic int calc_idw(input int nreq);
      return (nreq <= 2) ? 1 : $clog2(nreq);
   endfunction

   function automatic logic [TAG_MAXW-1:0] pack_tag(input int unsigned idx,
                                                    input logic [TAG_MAXW-1:0] data,
                                                    input int unsigned width);
      return (TAG_MAXW'(idx) << width) | data;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   int             cand;
   logic [IDW-1:0] ci;

   // Scan from the farthest offset down so the nearest hit to rr_ptr wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      ci    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NREQ) cand = cand - NREQ;
         ci = IDW'(cand);
         if (req[ci]) begin
            found = 1'b1;
            idx   = ci;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NREQ producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 16,
   parameter int IDW       = calc_idw(NREQ)
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ-1:0]       req_last_i,
   input  logic [NREQ*WIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]       req_ready_o,
   input  logic                  fifo_full_i,
   output logic                  fifo_wr_o,
   output logic [IDW+WIDTH-1:0]  fifo_wr_data_o,
   output logic [NREQ-1:0]       grant_o,
   output logic                  busy_o,
   output logic                  forced_rel_o
);

   localparam int             BCW      = $clog2(MAX_BURST) + 1;
   localparam logic [BCW-1:0] BEAT_MAX = BCW'(MAX_BURST - 1);

   state_t           state_q, state_d;
   logic [IDW-1:0]   gnt_q, gnt_d, rr_q, rr_d, pick_idx, g_next;
   logic [BCW-1:0]   beat_q, beat_d;
   logic             pick_found, xfer, cut, forced_q, forced_d;
   logic [WIDTH-1:0] g_data;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req    (req_valid_i),
      .rr_ptr (rr_q),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   assign busy_o = (state_q == BURST);
   assign g_data = req_data_i[gnt_q*WIDTH +: WIDTH];
   assign g_next = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;

   // Reset gates the write strobe so an abandoned burst never lands a word.
   assign xfer      = busy_o && resetn_i && !fifo_full_i && req_valid_i[gnt_q];
   assign cut       = xfer && (beat_q == BEAT_MAX);
   assign fifo_wr_o = xfer;
   assign fifo_wr_data_o = (IDW+WIDTH)'(pack_tag(32'(gnt_q), TAG_MAXW'(g_data), 32'(WIDTH)));
   assign forced_rel_o   = forced_q;

   always_comb begin
      req_ready_o = '0;
      grant_o     = '0;
      if (busy_o) begin
         grant_o[gnt_q]     = 1'b1;
         req_ready_o[gnt_q] = resetn_i && !fifo_full_i;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      rr_d     = rr_q;
      beat_d   = beat_q;
      forced_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = BURST;
               gnt_d   = pick_idx;
               beat_d  = '0;
            end
         end
         BURST: begin
            if (xfer) begin
               if (req_last_i[gnt_q] || cut) begin
                  state_d  = IDLE;
                  gnt_d    = '0;
                  beat_d   = '0;
                  rr_d     = g_next;
                  forced_d = cut && !req_last_i[gnt_q];
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rr_q     <= '0;
         beat_q   <= '0;
         forced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_q     <= rr_d;
         beat_q   <= beat_d;
         forced_q <= forced_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven cycle checks plus scoreboarded producer sequences for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int IDW = 2;

   typedef logic [IDW+W-1:0] word_t;
   typedef struct packed { logic last; logic [W-1:0] data; } beat_t;
   typedef struct packed {
      logic         rstn;
      logic [N-1:0] valid;
      logic         full;
      logic [N-1:0] e_ready;
      logic         e_wr;
      logic [N-1:0] e_grant;
      logic         e_busy;
      logic [1:0]   e_tag;
   } vec_t;

   logic           clk_i = 1'b0;
   logic           resetn_i, fifo_full_i;
   logic [N-1:0]   req_valid_i, req_last_i;
   logic [N*W-1:0] req_data_i;
   logic [N-1:0]   rdy_a, gnt_a, rdy_b, gnt_b;
   logic           wr_a, busy_a, fr_a, wr_b, busy_b, fr_b;
   word_t          wd_a, wd_b;

   fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BURST(16)) dut (
      .clk_i(clk_i), .resetn_i(resetn_i), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
      .req_data_i(req_data_i), .req_ready_o(rdy_a), .fifo_full_i(fifo_full_i), .fifo_wr_o(wr_a),
      .fifo_wr_data_o(wd_a), .grant_o(gnt_a), .busy_o(busy_a), .forced_rel_o(fr_a));

   fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BURST(4)) dut4 (
      .clk_i(clk_i), .resetn_i(resetn_i), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
      .req_data_i(req_data_i), .req_ready_o(rdy_b), .fifo_full_i(fifo_full_i), .fifo_wr_o(wr_b),
      .fifo_wr_data_o(wd_b), .grant_o(gnt_b), .busy_o(busy_b), .forced_rel_o(fr_b));

   always #5 clk_i = ~clk_i;

   int    n_vec, n_err, cyc_n, fr_cnt, n3;
   bit    sel4;
   beat_t pq[N][$];
   word_t sbq[$];
   int    wr_cyc[$];
   vec_t  tv[19];
   logic [N-1:0] s_rdy, s_gnt;
   logic         s_wr, s_busy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic word_t mkw(input int k, input int j);
      return {IDW'(k), 8'(8'hC0 + k), 24'(j)};
   endfunction

   // mode 0: never last, 1: last on final beat, 2: last on every beat
   task automatic load(input int k, input int n, input int j0, input int mode);
      beat_t b;
      for (int j = 0; j < n; j++) begin
         b.data = mkw(k, j0 + j)[W-1:0];
         b.last = (mode == 2) || (mode == 1 && j == n - 1);
         pq[k].push_back(b);
      end
   endtask

   task automatic push_exp(input int k, input int j0, input int n);
      for (int j = 0; j < n; j++) sbq.push_back(mkw(k, j0 + j));
   endtask

   // One cycle: drive producers at negedge, sample 1 ns later, retire accepted beats.
   task automatic cyc(input bit full, input bit rstn);
      logic  wr, fr;
      word_t wd;
      @(negedge clk_i);
      cyc_n++;
      resetn_i    = rstn;
      fifo_full_i = full;
      for (int k = 0; k < N; k++) begin
         req_valid_i[k]       = (pq[k].size() > 0);
         req_last_i[k]        = req_valid_i[k] ? pq[k][0].last : 1'b0;
         req_data_i[k*W +: W] = req_valid_i[k] ? pq[k][0].data : '0;
      end
      #1;
      s_rdy  = sel4 ? rdy_b  : rdy_a;
      s_gnt  = sel4 ? gnt_b  : gnt_a;
      s_busy = sel4 ? busy_b : busy_a;
      wr     = sel4 ? wr_b   : wr_a;
      wd     = sel4 ? wd_b   : wd_a;
      fr     = sel4 ? fr_b   : fr_a;
      s_wr   = wr;
      chk("wr_matches_handshake", wr, |(s_rdy & req_valid_i));
      if (wr) begin
         wr_cyc.push_back(cyc_n);
         if (wd[W +: IDW] == 2'd3) n3++;
         if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got %0h, expected no write", wd);
         end else begin
            chk("fifo_word", wd, sbq.pop_front());
         end
      end
      if (fr) begin
         fr_cnt++;
         chk("forced_at_chunk_edge", 64'(n3 % 4), 0);
      end
      for (int k = 0; k < N; k++)
         if (s_rdy[k] && req_valid_i[k]) void'(pq[k].pop_front());
   endtask

   task automatic run(input int budget, input int stall_at, input int stall_len);
      int  stalled;
      bit  f;
      stalled = 0;
      for (int t = 0; t < budget && sbq.size() > 0; t++) begin
         f = (wr_cyc.size() == stall_at) && (stalled < stall_len);
         if (f) stalled++;
         cyc(f, 1'b1);
         if (f) begin
            chk("stall_ready", s_rdy, 0);
            chk("stall_wr", s_wr, 0);
            chk("stall_busy", s_busy, 1);
         end
      end
      chk("run_complete", sbq.size(), 0);
   endtask

   task automatic do_reset();
      for (int k = 0; k < N; k++) pq[k].delete();
      sbq.delete();
      wr_cyc.delete();
      fr_cnt = 0;
      n3     = 0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc_n = 0; fr_cnt = 0; n3 = 0; sel4 = 1'b0;
      resetn_i = 1'b0; fifo_full_i = 1'b0;
      req_valid_i = '0; req_last_i = '0; req_data_i = '0;

      // rstn valid full | ready wr grant busy tag   (last held at 1111)
      tv = '{
         '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0},
         '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b1, 4'b0101, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2},
         '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b1, 4'b0101, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0},
         '{1'b1, 4'b1101, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b1, 4'b1101, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2},
         '{1'b1, 4'b1101, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b1, 4'b1101, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3},
         '{1'b1, 4'b1101, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b1, 4'b1101, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0},
         '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0},
         '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1},
         '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1},
         '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0}
      };

      repeat (2) @(negedge clk_i);
      foreach (tv[i]) begin
         @(negedge clk_i);
         resetn_i    = tv[i].rstn;
         req_valid_i = tv[i].valid;
         req_last_i  = '1;
         fifo_full_i = tv[i].full;
         for (int k = 0; k < N; k++) req_data_i[k*W +: W] = 32'hA000_0000 + k;
         #1;
         chk($sformatf("tv%0d_ready", i), rdy_a, tv[i].e_ready);
         chk($sformatf("tv%0d_wr", i), wr_a, tv[i].e_wr);
         chk($sformatf("tv%0d_grant", i), gnt_a, tv[i].e_grant);
         chk($sformatf("tv%0d_busy", i), busy_a, tv[i].e_busy);
         chk($sformatf("tv%0d_forced", i), fr_a, 0);
         if (tv[i].e_wr)
            chk($sformatf("tv%0d_data", i), wd_a, {tv[i].e_tag, 32'hA000_0000 + 32'(tv[i].e_tag)});
      end

      // Burst lock: 5-beat burst from 1 while 0 waits, then one bubble, then 0.
      do_reset();
      load(0, 1, 0, 1); push_exp(0, 0, 1); run(20, -1, 0);
      wr_cyc.delete();
      load(1, 5, 0, 1); load(0, 1, 1, 1);
      push_exp(1, 0, 5); push_exp(0, 1, 1);
      run(40, -1, 0);
      chk("lock_writes", wr_cyc.size(), 6);
      if (wr_cyc.size() == 6) begin
         for (int j = 0; j < 4; j++) chk("lock_consecutive", 64'(wr_cyc[j+1] - wr_cyc[j]), 1);
         chk("lock_bubble", 64'(wr_cyc[5] - wr_cyc[4]), 2);
      end
      chk("lock_no_forced", fr_cnt, 0);

      // Backpressure: FIFO full for 3 cycles after the third beat of 8.
      do_reset();
      load(2, 8, 0, 1); push_exp(2, 0, 8);
      run(40, 3, 3);
      chk("bp_writes", wr_cyc.size(), 8);
      chk("bp_drained", pq[2].size(), 0);

      // Reset after beat 2 of 6: rest abandoned, pointer back to 0.
      do_reset();
      load(0, 1, 0, 1); push_exp(0, 0, 1); run(20, -1, 0);
      wr_cyc.delete();
      load(1, 6, 0, 1); push_exp(1, 0, 2);
      for (int t = 0; t < 20 && wr_cyc.size() < 2; t++) cyc(1'b0, 1'b1);
      chk("rst_beats_before", wr_cyc.size(), 2);
      cyc(1'b0, 1'b0);
      chk("rst_cycle_wr", s_wr, 0);
      chk("rst_cycle_ready", s_rdy, 0);
      pq[1].delete();
      cyc(1'b0, 1'b1);
      chk("rst_after_busy", s_busy, 0);
      chk("rst_after_grant", s_gnt, 0);
      chk("rst_sb_empty", sbq.size(), 0);
      for (int k = 0; k < N; k++) begin
         load(k, 1, 10, 1);
         push_exp(k, 10, 1);
      end
      run(40, -1, 0);

      // Forced release on the MAX_BURST=4 instance: 3 streams 10 beats, 0 interleaves.
      do_reset();
      sel4 = 1'b1;
      load(3, 10, 0, 0); load(0, 2, 0, 2);
      push_exp(0, 0, 1); push_exp(3, 0, 4); push_exp(0, 1, 1);
      push_exp(3, 4, 4); push_exp(3, 8, 2);
      run(100, -1, 0);
      chk("forced_pulses", fr_cnt, 2);
      sel4 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the synchronous FIFO between NREQ independent producers (QSPI command path, status poller, debug injector, etc.).
- Grants one requester at a time, with round-robin fairness and burst locking.
- Tags each written word with the source index, so the FIFO consumer can demultiplex.
- Sits directly in front of the FIFO write port and obeys the FIFO's full flag.

Parameters:
- WIDTH, 32, payload width per requester.
- NREQ, 4, number of requesters (2..16).
- MAX_BURST, 16, maximum beats per grant before forced release (power of 2, >=1).
- IDW, $clog2(NREQ), derived; width of source tag.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- resetn_i  in  1  synchronous active-low reset.
- req_valid_i  in  NREQ  per-requester data valid.
- req_last_i  in  NREQ  per-requester last beat of burst; qualified by valid.
- req_data_i  in  NREQ*WIDTH  packed payloads; requester k occupies bits [k*WIDTH +: WIDTH].
- req_ready_o  out  NREQ  per-requester accept; at most one bit set.
- fifo_full_i  in  1  full flag from FIFO.
- fifo_wr_o  out  1  FIFO write strobe.
- fifo_wr_data_o  out  IDW+WIDTH  {source index, payload}.
- grant_o  out  NREQ  one-hot current grant; 0 when idle.
- busy_o  out  1  high while in BURST state.
- forced_rel_o  out  1  one-cycle pulse when a burst is cut at MAX_BURST.

Behaviour:
- Reset (resetn_i low at a clock edge):
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, forced_rel_o=0.
  - Because of this, req_ready_o=0 and fifo_wr_o=0.
  - Reset overrides any in-progress burst; the partial burst is abandoned and no further words are written for it.
- State IDLE:
  - req_ready_o=0; fifo_wr_o=0.
  - If any req_valid_i bit is set, register grant = the first set index scanning rr_ptr, rr_ptr+1, ... modulo NREQ, then go to BURST.
  - Arbitration latency: 1 cycle from valid to grant. The earliest transfer is the cycle after the grant registers.
- State BURST, granted index g:
  - req_ready_o[g] = !fifo_full_i (combinational); all other ready bits are 0.
  - Transfer = req_valid_i[g] && req_ready_o[g].
  - fifo_wr_o = transfer, combinational.
  - fifo_wr_data_o = {g, req_data_i[g]}; it is don't-care when fifo_wr_o=0.
  - On each transfer, beat_cnt increments.
  - Release when a transfer has req_last_i[g]=1, or when a transfer occurs with beat_cnt==MAX_BURST-1. In the second case only, pulse forced_rel_o for one cycle.
  - On release: state=IDLE, grant=0, beat_cnt=0, rr_ptr=(g+1) mod NREQ.
  - The granted requester may deassert valid mid-burst; the grant holds with no timeout.
  - fifo_full_i high stalls the burst; no state change while stalled.
- Boundaries:
  - Back-to-back bursts always pass through IDLE, giving exactly 1 bubble cycle.
  - Requesters that are valid but not granted wait and must hold data and last stable.
  - The rr_ptr wrap from NREQ-1 goes to 0.
  - A single-beat burst (last on the first beat) is legal.
  - MAX_BURST=1 releases after every beat; forced_rel_o pulses whenever last=0 on that beat.
  - fifo_full_i is sampled combinationally, so the arbiter never writes into a full FIFO and the FIFO never drops a word.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST)+1 bits.
  - rr_ptr and g are IDW bits; the modulo is explicit for non-power-of-2 NREQ.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - a function for the IDW computation;
  - a function for the tag packing helper.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: found flag, index.
  - Instantiated once for the IDLE decision.
- The top level holds the FSM, beat counter and output muxing.

Test Plan:
- Reset and idle: hold resetn_i=0 for 3 cycles with all valids high -> req_ready_o=0, fifo_wr_o=0, grant_o=0. Release reset -> grant_o=4'b0001 one cycle later.
- Round-robin: requesters 0 and 2 continuously valid, each burst 1 beat with last=1 -> FIFO tags alternate 0,2,0,2 with one bubble between writes. Adding requester 3 gives order 0,2,3,0.
- Burst lock: requester 1 sends 5 beats (last on beat 5) while 0 is valid -> 5 consecutive writes tagged 1, payloads in order, then requester 0 is granted.
- Forced release: MAX_BURST=4, requester 3 streams 10 beats with no last -> forced_rel_o pulses after beats 4 and 8. With others valid, other requesters are served between the chunks.
- Backpressure: fifo_full_i=1 for 3 cycles mid-burst -> req_ready_o=0 and fifo_wr_o=0 during those cycles. The burst resumes with no lost or duplicated beats; the scoreboard matches all 8 words.
- Reset mid-burst: resetn_i=0 after beat 2 of 6 -> the next cycle shows state IDLE and rr_ptr=0, and no write occurs during reset.
